speed_tick_ctrl: RTL and testbench

// - Rate controller for the LCD-kit timing path: picks one of three step rates (2/5/10 Hz
//   at 50 MHz) from the "speed" push-button and emits a one-cycle tick enable plus a

---
 rtl/speed_pkg.sv | 24 ++
 rtl/btn_debounce.sv | 54 +++++
 rtl/speed_tick_ctrl.sv | 91 +++++++++
 tb/tb_speed_tick_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/speed_pkg.sv
// Shared rate-index constants, default period lengths and the pending-index step function.
// Pure definitions; no latency and no flow control.
package speed_pkg;

    localparam int SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_2HZ  = 2'd0;
    localparam logic [SEL_W-1:0] SEL_5HZ  = 2'd1;
    localparam logic [SEL_W-1:0] SEL_10HZ = 2'd2;

    localparam int DIV0_DEF = 25_000_000;
    localparam int DIV1_DEF = 10_000_000;
    localparam int DIV2_DEF = 5_000_000;

    // Index 3 is never produced but must fall back to the slowest rate.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] cur);
        case (cur)
            SEL_2HZ: next_sel = SEL_5HZ;
            SEL_5HZ: next_sel = SEL_10HZ;
            default: next_sel = SEL_2HZ;
        endcase
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button synchronizer + debouncer emitting one press pulse per debounced 0->1 edge.
// Press lags the raw edge by 2 sync cycles + DB_CYCLES stable cycles + 1; no backpressure.
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rs,
    input  logic btn_raw,
    output logic press
);

    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DW-1:0] DB_LAST = DW'(DB_CYCLES - 1);
    localparam logic [DW-1:0] DB_ONE  = DW'(1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic          press_q, press_d;
    logic [DW-1:0] dbc_q, dbc_d;

    // Any sample agreeing with the debounced level restarts the stability window.
    always_comb begin
        dbc_d   = '0;
        db_d    = db_q;
        press_d = 1'b0;
        if (sync2_q != db_q) begin
            if (dbc_q == DB_LAST) begin
                db_d    = sync2_q;
                press_d = sync2_q;
            end else begin
                dbc_d = dbc_q + DB_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            dbc_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            dbc_q   <= dbc_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/speed_tick_ctrl.sv
// Selectable-rate tick/square-wave generator; rate switches only at period boundaries.
// tick is registered, one cycle after the last count of a period; no backpressure, frez stalls.
module speed_tick_ctrl
    import speed_pkg::*;
#(
    parameter int DIV0      = DIV0_DEF,
    parameter int DIV1      = DIV1_DEF,
    parameter int DIV2      = DIV2_DEF,
    parameter int DB_CYCLES = 1_000_000,
    parameter int CW        = 25
) (
    input  logic             clk,
    input  logic             rs,
    input  logic             speed,
    input  logic             frez,
    output logic             tick,
    output logic             clko,
    output logic [SEL_W-1:0] sel
);

    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    function automatic logic [CW-1:0] div_of(input logic [SEL_W-1:0] s);
        case (s)
            SEL_5HZ:  div_of = CW'(DIV1);
            SEL_10HZ: div_of = CW'(DIV2);
            default:  div_of = CW'(DIV0);
        endcase
    endfunction

    logic             press;
    logic [SEL_W-1:0] pend_q, pend_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    div_cur, div_nxt;
    logic             tick_q, tick_d;
    logic             clko_q, clko_d;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) u_btn (
        .clk    (clk),
        .rs     (rs),
        .btn_raw(speed),
        .press  (press)
    );

    // The boundary loads the pending index as registered before this edge, so a
    // press landing on the wrap cycle only takes effect one period later.
    always_comb begin
        pend_d  = press ? next_sel(pend_q) : pend_q;
        div_cur = div_of(sel_q);
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        tick_d  = 1'b0;
        clko_d  = clko_q;
        div_nxt = div_cur;
        if (!frez) begin
            if (cnt_q == div_cur - CNT_ONE) begin
                cnt_d  = '0;
                tick_d = 1'b1;
                sel_d  = pend_q;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
            div_nxt = div_of(sel_d);
            clko_d  = (cnt_d < (div_nxt >> 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rs) begin
            pend_q <= SEL_2HZ;
            sel_q  <= SEL_2HZ;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            clko_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            sel_q  <= sel_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            clko_q <= clko_d;
        end
    end

    assign tick = tick_q;
    assign clko = clko_q;
    assign sel  = sel_q;

endmodule

// File: tb/tb_speed_tick_ctrl.sv
// Scoreboard bench for speed_tick_ctrl: directed scenarios plus random button/freeze/reset traffic.
module tb_speed_tick_ctrl;
    import speed_pkg::*;

    localparam int DIV0 = 10;
    localparam int DIV1 = 4;
    localparam int DIV2 = 2;
    localparam int DBC  = 3;
    localparam int CW   = 25;

    logic       clk   = 1'b0;
    logic       rs    = 1'b1;
    logic       speed = 1'b0;
    logic       frez  = 1'b0;
    logic       tick;
    logic       clko;
    logic [1:0] sel;

    always #5 clk = ~clk;

    speed_tick_ctrl #(
        .DIV0(DIV0), .DIV1(DIV1), .DIV2(DIV2), .DB_CYCLES(DBC), .CW(CW)
    ) dut (
        .clk  (clk),
        .rs   (rs),
        .speed(speed),
        .frez (frez),
        .tick (tick),
        .clko (clko),
        .sel  (sel)
    );

    typedef struct packed {
        logic       tick;
        logic       clko;
        logic [1:0] sel;
    } exp_t;

    exp_t sb_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_tick = 0;
    int   spacing = 0;

    // Reference model state, all values as seen after the upcoming edge.
    int m_s1, m_s2, m_db, m_run, m_press, m_pend, m_sel, m_pos, m_tick, m_clko;

    function automatic int period_of(input int s);
        if (s == 1) return DIV1;
        if (s == 2) return DIV2;
        return DIV0;
    endfunction

    function automatic int step_pend(input int p);
        return (p >= 2) ? 0 : p + 1;
    endfunction

    task automatic model_edge(input logic r, input logic sp, input logic fz);
        int old_pend;
        int len;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_db = 0; m_run = 0; m_press = 0;
            m_pend = 0; m_sel = 0; m_pos = 0; m_tick = 0; m_clko = 0;
        end else begin
            old_pend = m_pend;
            if (m_press != 0) m_pend = step_pend(m_pend);
            m_press = 0;
            // The debounced level flips after DBC consecutive disagreeing samples.
            if (m_s2 != m_db) begin
                m_run++;
                if (m_run == DBC) begin
                    m_db    = m_s2;
                    m_run   = 0;
                    m_press = m_db;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = int'(sp);
            if (fz) begin
                m_tick = 0;
            end else begin
                len = period_of(m_sel);
                m_pos++;
                if (m_pos == len) begin
                    m_pos  = 0;
                    m_tick = 1;
                    m_sel  = old_pend;
                end else begin
                    m_tick = 0;
                end
                m_clko = (m_pos < period_of(m_sel) / 2) ? 1 : 0;
            end
        end
    endtask

    task automatic drive(input logic r, input logic sp, input logic fz);
        exp_t e;
        @(negedge clk);
        rs    = r;
        speed = sp;
        frez  = fz;
        model_edge(r, sp, fz);
        e.tick = m_tick[0];
        e.clko = m_clko[0];
        e.sel  = m_sel[1:0];
        sb_q.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic do_reset();
        repeat (3) drive(1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares DUT outputs every cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (tick === 1'b1) begin
                spacing   = cyc - last_tick;
                last_tick = cyc;
            end
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                tests++;
                if ({tick, clko, sel} !== e) begin
                    fails++;
                    $display("FAIL cycle%0d tick/clko/sel: got %b/%b/%0d, expected %b/%b/%0d",
                             cyc, tick, clko, sel, e.tick, e.clko, e.sel);
                end
            end
        end
    end

    initial begin
        bit sp_v;
        bit fz_v;
        int hold;

        // Reset and steady 2 Hz-equivalent rate.
        do_reset();
        settle();
        check("reset_tick", int'(tick), 0);
        check("reset_clko", int'(clko), 0);
        check("reset_sel", int'(sel), 0);
        idle(35);
        settle();
        check("spacing_div0", spacing, 10);

        // Freeze at cnt=5 with a press inside the freeze.
        for (int i = 0; i < 40 && m_pos != 5; i++) idle(1);
        drive(1'b0, 1'b0, 1'b1);
        repeat (4) drive(1'b0, 1'b1, 1'b1);
        repeat (15) drive(1'b0, 1'b0, 1'b1);
        settle();
        check("frez_cnt_held", int'(dut.cnt_q), 5);
        check("frez_clko_held", int'(clko), 0);
        check("frez_sel_held", int'(sel), 0);
        check("frez_pend_moved", int'(dut.pend_q), 1);
        idle(5);
        settle();
        check("frez_resume_tick", int'(tick), 1);
        check("frez_resume_sel", int'(sel), 1);

        // Press pulse landing exactly on the wrap edge.
        do_reset();
        for (int i = 0; i < 40 && m_pos != 4; i++) idle(1);
        repeat (4) drive(1'b0, 1'b1, 1'b0);
        idle(2);
        settle();
        check("wrap_press_tick", int'(tick), 1);
        check("wrap_press_sel_old", int'(sel), 0);
        check("wrap_press_pend", int'(dut.pend_q), 1);
        idle(10);
        settle();
        check("wrap_press_tick2", int'(tick), 1);
        check("wrap_press_sel_new", int'(sel), 1);

        // Bouncy press gives exactly one step.
        do_reset();
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        repeat (10) drive(1'b0, 1'b1, 1'b0);
        idle(38);
        settle();
        check("bounce_pend", int'(dut.pend_q), 1);
        check("bounce_sel", int'(sel), 1);
        check("spacing_div1", spacing, 4);

        // Second press then reset mid-period.
        repeat (3) drive(1'b0, 1'b1, 1'b0);
        idle(6);
        settle();
        check("pre_reset_pend", int'(dut.pend_q), 2);
        do_reset();
        settle();
        check("midreset_sel", int'(sel), 0);
        check("midreset_pend", int'(dut.pend_q), 0);
        check("midreset_tick", int'(tick), 0);
        idle(25);
        settle();
        check("midreset_spacing", spacing, 10);

        // Random traffic: button held for random spans, occasional freeze and reset.
        for (int n = 0; n < 2500; ) begin
            sp_v = 1'($urandom_range(0, 1));
            fz_v = ($urandom_range(0, 7) == 0);
            hold = $urandom_range(1, 8);
            for (int k = 0; k < hold; k++) begin
                drive(($urandom_range(0, 499) == 0), sp_v, fz_v);
                n++;
            end
        end

        idle(2);
        settle();
        settle();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
